control_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute sequencer directly upstream of the 16-bit ALU.

---
 rtl/isa_pkg.sv | 37 +++
 rtl/cs_decode.sv | 23 ++
 rtl/control_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the sequencer: opcodes, write-back source codes
// and the FSM state encoding.
package isa_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_END  = 4'd1;
   localparam logic [3:0] OP_RST  = 4'd2;
   localparam logic [3:0] OP_MOV  = 4'd3;
   localparam logic [3:0] OP_LOAD = 4'd4;
   localparam logic [3:0] OP_STO  = 4'd5;
   localparam logic [3:0] OP_LDI  = 4'd6;
   localparam logic [3:0] OP_ADD  = 4'd7;
   localparam logic [3:0] OP_SUB  = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;
   localparam logic [3:0] OP_OR   = 4'd10;
   localparam logic [3:0] OP_XOR  = 4'd11;
   localparam logic [3:0] OP_NOT  = 4'd12;
   localparam logic [3:0] OP_ROOF = 4'd13;
   localparam logic [3:0] OP_SHL  = 4'd14;
   localparam logic [3:0] OP_JMPZ = 4'd15;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_REG = 2'd1;
   localparam logic [1:0] WB_IMM = 2'd2;
   localparam logic [1:0] WB_MEM = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

endpackage

// File: rtl/cs_decode.sv
// Combinational opcode classifier: ALU/memory class flags and the
// write-back source used when the instruction reaches WB.
module cs_decode
   import isa_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_alu,
   output logic       is_mem,
   output logic [1:0] wb_sel
);

   always_comb begin
      is_alu = (opcode >= OP_ADD) && (opcode <= OP_SHL);
      is_mem = (opcode == OP_LOAD) || (opcode == OP_STO);
      case (opcode)
         OP_MOV:  wb_sel = WB_REG;
         OP_LDI:  wb_sel = WB_IMM;
         OP_LOAD: wb_sel = WB_MEM;
         default: wb_sel = WB_ALU;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer feeding the 16-bit ALU, register file and
// data memory; resolves JMPZ from the ALU zero flag.
//
//  state  | meaning
//  IDLE   | waiting for start after reset
//  FETCH  | imem_rd asserted at PC
//  DECODE | instruction word on imem_data, dispatch and PC update
//  EXEC   | opcode presented to the ALU for one cycle
//  MEM    | data memory read (LOAD) or write (STO)
//  WB     | register write from the selected source
//  HALT   | END reached, done high until next start
module control_sequencer
   import isa_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int REG_SEL_W = 4
)
(
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   output logic                 imem_rd,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic [DATA_W-1:0]    imem_data,
   output logic [3:0]           alu_op,
   input  logic                 z_flag,
   output logic [REG_SEL_W-1:0] rd_sel,
   output logic [REG_SEL_W-1:0] rs_sel,
   output logic [DATA_W-1:0]    imm,
   output logic [1:0]           wb_sel,
   output logic                 reg_wr,
   output logic                 reg_clr,
   output logic [ADDR_W-1:0]    dmem_addr,
   output logic                 dmem_rd,
   output logic                 dmem_wr,
   output logic                 busy,
   output logic                 done
);

   state_t              state_q, next_state;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [3:0]          op_cur;
   logic                is_alu, is_mem;
   logic [1:0]          dec_wb_sel;

   logic                imem_rd_d, reg_wr_d, dmem_rd_d, dmem_wr_d, busy_d, done_d;
   logic [3:0]          alu_op_d;
   logic [1:0]          wb_sel_d;

   // In DECODE the word is still on the bus; afterwards IR holds it.
   assign op_cur = (state_q == S_DECODE) ? imem_data[15:12] : ir_q[15:12];

   cs_decode u_decode (
      .opcode (op_cur),
      .is_alu (is_alu),
      .is_mem (is_mem),
      .wb_sel (dec_wb_sel)
   );

   always_comb begin
      next_state = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               next_state = S_FETCH;
               pc_d       = '0;
            end
         end
         S_FETCH: next_state = S_DECODE;
         S_DECODE: begin
            ir_d = imem_data;
            pc_d = pc_q + ADDR_W'(1);
            if (is_alu) begin
               next_state = S_EXEC;
            end else if (is_mem) begin
               next_state = S_MEM;
            end else begin
               case (op_cur)
                  OP_END: begin
                     next_state = S_HALT;
                     pc_d       = pc_q;
                  end
                  OP_RST: begin
                     next_state = S_FETCH;
                     pc_d       = '0;
                  end
                  OP_MOV, OP_LDI: next_state = S_WB;
                  OP_JMPZ: begin
                     next_state = S_FETCH;
                     if (z_flag) pc_d = ADDR_W'(imem_data[7:0]);
                  end
                  default: next_state = S_FETCH;
               endcase
            end
         end
         S_EXEC:  next_state = S_WB;
         S_MEM:   next_state = (op_cur == OP_LOAD) ? S_WB : S_FETCH;
         S_WB:    next_state = S_FETCH;
         default: next_state = S_IDLE;
      endcase
   end

   // Outputs are registered from the state being entered so they line up
   // exactly with that state.
   always_comb begin
      imem_rd_d = (next_state == S_FETCH);
      reg_wr_d  = (next_state == S_WB);
      dmem_rd_d = (next_state == S_MEM) && (op_cur == OP_LOAD);
      dmem_wr_d = (next_state == S_MEM) && (op_cur == OP_STO);
      alu_op_d  = (next_state == S_EXEC) ? op_cur : OP_NOP;
      wb_sel_d  = (next_state == S_WB) ? dec_wb_sel : WB_ALU;
      busy_d    = (next_state != S_IDLE) && (next_state != S_HALT);
      done_d    = (next_state == S_HALT);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         imem_rd <= 1'b0;
         reg_wr  <= 1'b0;
         dmem_rd <= 1'b0;
         dmem_wr <= 1'b0;
         alu_op  <= OP_NOP;
         wb_sel  <= WB_ALU;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= next_state;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         imem_rd <= imem_rd_d;
         reg_wr  <= reg_wr_d;
         dmem_rd <= dmem_rd_d;
         dmem_wr <= dmem_wr_d;
         alu_op  <= alu_op_d;
         wb_sel  <= wb_sel_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // RST must clear within its 2-cycle slot, so the pulse is decoded in DECODE
   // from the registered memory word rather than delayed into FETCH.
   assign reg_clr   = (state_q == S_DECODE) && (op_cur == OP_RST);
   assign imem_addr = pc_q;
   assign rd_sel    = ir_q[11:8];
   assign rs_sel    = ir_q[7:4];
   assign imm       = {{(DATA_W-8){1'b0}}, ir_q[7:0]};
   assign dmem_addr = ADDR_W'(ir_q[7:0]);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed programs push expected
// strobe events (kind, value, cycle offset from start); a monitor pops them.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset_n, start, z_flag;
   logic        imem_rd, reg_wr, reg_clr, dmem_rd, dmem_wr, busy, done;
   logic [7:0]  imem_addr, dmem_addr;
   logic [15:0] imem_data = 16'h0;
   logic [15:0] imm;
   logic [3:0]  alu_op, rd_sel, rs_sel;
   logic [1:0]  wb_sel;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
      .alu_op(alu_op), .z_flag(z_flag), .rd_sel(rd_sel), .rs_sel(rs_sel),
      .imm(imm), .wb_sel(wb_sel), .reg_wr(reg_wr), .reg_clr(reg_clr),
      .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
      .busy(busy), .done(done)
   );

   logic [15:0] mem [256];
   always @(posedge clock) if (imem_rd) imem_data <= mem[imem_addr];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;
   int t0 = 0;

   localparam int K_FETCH = 0, K_EXEC = 1, K_WB = 2, K_MRD = 3, K_MWR = 4, K_CLR = 5, K_DONE = 6;
   typedef struct {int kind; logic [31:0] val; int rel;} ev_t;
   ev_t exp_q[$];
   int n_tests = 0, n_fail = 0;

   function automatic string kname(int k);
      case (k)
         K_FETCH: return "fetch";
         K_EXEC:  return "exec";
         K_WB:    return "wb";
         K_MRD:   return "dmem_rd";
         K_MWR:   return "dmem_wr";
         K_CLR:   return "reg_clr";
         default: return "done";
      endcase
   endfunction

   task automatic expect_ev(int k, logic [31:0] v, int r);
      ev_t e;
      e.kind = k; e.val = v; e.rel = r;
      exp_q.push_back(e);
   endtask

   task automatic observe(int k, logic [31:0] v);
      ev_t e;
      int r;
      r = cyc - t0;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: got val=%h rel=%0d, required no event", kname(k), v, r);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val !== v || e.rel != r) begin
            n_fail++;
            $display("FAIL event_%s: got %s val=%h rel=%0d, required %s val=%h rel=%0d",
                     kname(e.kind), kname(k), v, r, kname(e.kind), e.val, e.rel);
         end
      end
   endtask

   logic done_prev = 1'b0;
   int   nstrobe;
   always @(negedge clock) begin
      if (reset_n) begin
         if (reg_clr)     observe(K_CLR, 32'h0);
         if (imem_rd)     observe(K_FETCH, 32'(imem_addr));
         if (alu_op != 0) observe(K_EXEC, 32'(alu_op));
         if (dmem_rd)     observe(K_MRD, 32'(dmem_addr));
         if (dmem_wr)     observe(K_MWR, {20'h0, dmem_addr, rs_sel});
         if (reg_wr)      observe(K_WB, {imm, rd_sel, rs_sel, 6'h0, wb_sel});
         if (done && !done_prev) observe(K_DONE, 32'h0);
         nstrobe = int'(imem_rd) + int'(reg_wr) + int'(reg_clr) + int'(dmem_rd) + int'(dmem_wr);
         if (nstrobe > 0) begin
            n_tests++;
            if (nstrobe > 1) begin
               n_fail++;
               $display("FAIL strobe_exclusive: got %0d strobes at rel=%0d, required 1", nstrobe, cyc - t0);
            end
         end
      end
      done_prev = done;
   end

   task automatic do_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      t0    = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(string name);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge clock);
         #1;
         if (done) break;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: got done=0 after 60 cycles, required done=1", name);
      end
   endtask

   task automatic check_empty(string name);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_pending: got %0d unseen events, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset(string name);
      logic [63:0] outs;
      outs = {imem_rd, reg_wr, reg_clr, dmem_rd, dmem_wr, busy, done, alu_op, wb_sel,
              imem_addr, rd_sel, rs_sel, imm, dmem_addr};
      n_tests++;
      if (outs !== 64'h0) begin
         n_fail++;
         $display("FAIL %s: got outputs=%h, required all zero", name, outs);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200us, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; z_flag = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      repeat (3) @(posedge clock);
      #1 check_reset("reset_init");
      @(negedge clock) reset_n = 1'b1;

      // LDI r1,5; LDI r2,3; ADD r1,r2; END
      mem[0] = 16'h6105; mem[1] = 16'h6203; mem[2] = 16'h7120; mem[3] = 16'h1000;
      expect_ev(K_FETCH, 32'h00, 0);  expect_ev(K_WB, 32'h0005_1002, 2);
      expect_ev(K_FETCH, 32'h01, 3);  expect_ev(K_WB, 32'h0003_2002, 5);
      expect_ev(K_FETCH, 32'h02, 6);  expect_ev(K_EXEC, 32'h7, 8);
      expect_ev(K_WB, 32'h0020_1200, 9); expect_ev(K_FETCH, 32'h03, 10);
      expect_ev(K_DONE, 32'h0, 12);
      do_start();
      wait_done("alu_prog");
      check_empty("alu_prog");

      // Same program aborted by reset during EXEC
      expect_ev(K_FETCH, 32'h00, 0);  expect_ev(K_WB, 32'h0005_1002, 2);
      expect_ev(K_FETCH, 32'h01, 3);  expect_ev(K_WB, 32'h0003_2002, 5);
      expect_ev(K_FETCH, 32'h02, 6);  expect_ev(K_EXEC, 32'h7, 8);
      do_start();
      repeat (8) @(posedge clock);
      @(negedge clock);
      #1 reset_n = 1'b0;
      #1 check_reset("reset_mid_exec");
      repeat (3) @(posedge clock);
      check_empty("reset_abort");
      @(negedge clock) reset_n = 1'b1;
      expect_ev(K_FETCH, 32'h00, 0);  expect_ev(K_WB, 32'h0005_1002, 2);
      expect_ev(K_FETCH, 32'h01, 3);  expect_ev(K_WB, 32'h0003_2002, 5);
      expect_ev(K_FETCH, 32'h02, 6);  expect_ev(K_EXEC, 32'h7, 8);
      expect_ev(K_WB, 32'h0020_1200, 9); expect_ev(K_FETCH, 32'h03, 10);
      expect_ev(K_DONE, 32'h0, 12);
      do_start();
      wait_done("restart");
      check_empty("restart");

      // JMPZ 0x20 taken and not taken
      mem[0] = 16'hF020; mem[1] = 16'h1000; mem[8'h20] = 16'h1000;
      z_flag = 1'b1;
      expect_ev(K_FETCH, 32'h00, 0); expect_ev(K_FETCH, 32'h20, 2); expect_ev(K_DONE, 32'h0, 4);
      do_start();
      wait_done("jmpz_taken");
      check_empty("jmpz_taken");
      z_flag = 1'b0;
      expect_ev(K_FETCH, 32'h00, 0); expect_ev(K_FETCH, 32'h01, 2); expect_ev(K_DONE, 32'h0, 4);
      do_start();
      wait_done("jmpz_not_taken");
      check_empty("jmpz_not_taken");

      // LOAD r3,0x40; STO r3,0x41; END
      mem[0] = 16'h4340; mem[1] = 16'h5341; mem[2] = 16'h1000;
      expect_ev(K_FETCH, 32'h00, 0); expect_ev(K_MRD, 32'h40, 2);
      expect_ev(K_WB, 32'h0040_3403, 3); expect_ev(K_FETCH, 32'h01, 4);
      expect_ev(K_MWR, 32'h0414, 6); expect_ev(K_FETCH, 32'h02, 7);
      expect_ev(K_DONE, 32'h0, 9);
      do_start();
      wait_done("load_store");
      check_empty("load_store");

      // NOP at 0xFF wraps the PC to 0x00
      mem[0] = 16'hF0FF; mem[1] = 16'h1000; mem[8'hFF] = 16'h0000;
      z_flag = 1'b1;
      expect_ev(K_FETCH, 32'h00, 0); expect_ev(K_FETCH, 32'hFF, 2);
      expect_ev(K_FETCH, 32'h00, 4); expect_ev(K_FETCH, 32'h01, 6);
      expect_ev(K_DONE, 32'h0, 8);
      do_start();
      repeat (3) @(posedge clock);
      #1 z_flag = 1'b0;
      wait_done("pc_wrap");
      check_empty("pc_wrap");

      // RST at 0x10, with a start pulse while busy
      mem[0] = 16'hF010; mem[1] = 16'h1000; mem[8'h10] = 16'h2000;
      z_flag = 1'b1;
      expect_ev(K_FETCH, 32'h00, 0); expect_ev(K_FETCH, 32'h10, 2);
      expect_ev(K_CLR, 32'h0, 3);    expect_ev(K_FETCH, 32'h00, 4);
      expect_ev(K_FETCH, 32'h01, 6); expect_ev(K_DONE, 32'h0, 8);
      do_start();
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(posedge clock);
      #1 z_flag = 1'b0;
      wait_done("rst_prog");
      check_empty("rst_prog");

      repeat (2) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
